// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the bus datapath control FSM.
package datapath_ctrl_pkg;

  localparam int CW      = 16;
  localparam int G_IDX   = 8;
  localparam int A_IDX   = 9;
  localparam int EXT_IDX = 10;
  localparam int ISR_IDX = 11;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4
  } state_t;

endpackage

// File: rtl/datapath_ctrl_dec3.sv
// 3-to-8 one-hot decoder for the X/Y register fields; purely combinational.
module datapath_ctrl_dec3 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  assign onehot = 8'b0000_0001 << sel;

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle control FSM: mv/mvi finish 2 cycles after accept, add/xor 4; run is ignored while busy.
// Optional perf outputs (instr_count, last_op) under DATAPATH_CTRL_PERF_EN.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic [7:0]    instruction,
  output logic [CW-1:0] rout,
  output logic [CW-1:0] ren,
  output logic          addxor,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state
`ifdef DATAPATH_CTRL_PERF_EN
  ,
  output logic [15:0]   instr_count,
  output logic [1:0]    last_op
`endif
);

  state_t     st;
  logic [7:0] ir;
  logic [7:0] xdec;
  logic [7:0] ydec;
  logic [1:0] op;

  assign op    = ir[7:6];
  assign state = st;

  datapath_ctrl_dec3 u_xdec (.sel(ir[5:3]), .onehot(xdec));
  datapath_ctrl_dec3 u_ydec (.sel(ir[2:0]), .onehot(ydec));

  // Outputs are loaded on the edge that enters a state, so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      ir     <= '0;
      rout   <= '0;
      ren    <= '0;
      addxor <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      rout   <= '0;
      ren    <= '0;
      addxor <= 1'b0;
      done   <= 1'b0;
      case (st)
        IDLE: begin
          if (run) begin
            ir           <= instruction;
            st           <= T0;
            busy         <= 1'b1;
            ren[ISR_IDX] <= 1'b1;
          end
        end
        T0: begin
          st        <= T1;
          ren[7:0]  <= xdec;
          done      <= (op == OP_MV) || (op == OP_MVI);
          if (op == OP_MV)
            rout[7:0] <= ydec;
          else if (op == OP_MVI)
            rout[EXT_IDX] <= 1'b1;
          else begin
            rout[7:0]  <= xdec;
            ren[7:0]   <= '0;
            ren[A_IDX] <= 1'b1;
          end
        end
        T1: begin
          if ((op == OP_MV) || (op == OP_MVI)) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else begin
            st         <= T2;
            rout[7:0]  <= ydec;
            ren[G_IDX] <= 1'b1;
            addxor     <= op[0];
          end
        end
        T2: begin
          st          <= T3;
          rout[G_IDX] <= 1'b1;
          ren[7:0]    <= xdec;
          done        <= 1'b1;
        end
        T3: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DATAPATH_CTRL_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
      last_op     <= '0;
    end else if (done) begin
      if (instr_count != 16'hFFFF)
        instr_count <= instr_count + 16'd1;
      last_op <= op;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: per-cycle expected control words are queued at issue time.
module tb_datapath_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  instruction = 8'h00;
  logic [15:0] rout, ren;
  logic        addxor, busy, done;
  logic [2:0]  state;
`ifdef DATAPATH_CTRL_PERF_EN
  logic [15:0] instr_count;
  logic [1:0]  last_op;
`endif

  datapath_ctrl dut (
    .clock(clock), .reset(reset), .run(run), .instruction(instruction),
    .rout(rout), .ren(ren), .addxor(addxor), .busy(busy), .done(done), .state(state)
`ifdef DATAPATH_CTRL_PERF_EN
    , .instr_count(instr_count), .last_op(last_op)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] rout;
    logic [15:0] ren;
    logic        ax;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic push(input logic [2:0] st, input logic [15:0] ro, input logic [15:0] re,
                      input logic ax, input logic dn);
    exp_t e;
    e.st = st; e.rout = ro; e.ren = re; e.ax = ax; e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every busy cycle must match the next queued control word.
  always @(negedge clock) begin
    if (mon_en && !reset && busy) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_busy: state %0d rout %h ren %h with empty queue", state, rout, ren);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (state !== e.st || rout !== e.rout || ren !== e.ren || addxor !== e.ax || done !== e.dn) begin
          n_err++;
          $display("FAIL ctrl_word: got st=%0d rout=%h ren=%h ax=%b done=%b expected st=%0d rout=%h ren=%h ax=%b done=%b",
                   state, rout, ren, addxor, done, e.st, e.rout, e.ren, e.ax, e.dn);
        end
      end
    end
  end

  // Drive one run pulse, wait for the queue to drain and the FSM to go idle.
  task automatic issue(input logic [7:0] ins, input string name);
    int t;
    @(negedge clock);
    run = 1'b1; instruction = ins;
    @(negedge clock);
    run = 1'b0; instruction = ~ins;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 20) begin
      @(negedge clock);
      t++;
    end
    check({name, "_drain_timeout"}, t < 20 ? 32'd0 : 32'd1, 32'd0);
    check({name, "_idle_after"}, {busy, done, state}, 32'd0);
    check({name, "_rout_idle"}, {rout, ren}, 32'd0);
  endtask

  initial begin
    int t;
    #1;
    check("reset_outputs", {rout, ren, addxor, busy, done, state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-add: assert while in T2.
    @(negedge clock);
    run = 1'b1; instruction = 8'b10_001_100;
    @(negedge clock);
    run = 1'b0;
    t = 0;
    while (state != 3'd3 && t < 10) begin
      @(negedge clock);
      t++;
    end
    check("reach_T2", {29'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    check("reset_midadd_rout", {16'd0, rout}, 32'd0);
    check("reset_midadd_ren", {16'd0, ren}, 32'd0);
    check("reset_midadd_busy", {busy, addxor, done, state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_after_reset", {29'd0, state}, 32'd0);
    end

    mon_en = 1'b1;

    // mvi R3,#5
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0400, 16'h0008, 1'b0, 1'b1);
    issue(8'b01_011_101, "mvi_r3_5");

    // mv R2,R6
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0040, 16'h0004, 1'b0, 1'b1);
    issue(8'b00_010_110, "mv_r2_r6");

    // add R1,R4
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0002, 16'h0200, 1'b0, 1'b0);
    push(3'd3, 16'h0010, 16'h0100, 1'b0, 1'b0);
    push(3'd4, 16'h0100, 16'h0002, 1'b0, 1'b1);
    issue(8'b10_001_100, "add_r1_r4");

    // xor R5,R5 with run held; instruction swapped to mv R1,R2 mid-flight.
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0020, 16'h0200, 1'b0, 1'b0);
    push(3'd3, 16'h0020, 16'h0100, 1'b1, 1'b0);
    push(3'd4, 16'h0100, 16'h0020, 1'b0, 1'b1);
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0004, 16'h0002, 1'b0, 1'b1);
    @(negedge clock);
    run = 1'b1; instruction = 8'b11_101_101;
    @(negedge clock);
    instruction = 8'b00_001_010;
    repeat (3) @(negedge clock);
    check("xor_done_cycle", {31'd0, done}, 32'd1);
    @(negedge clock);
    check("xor_gap_idle", {busy, state}, 32'd0);
    @(negedge clock);
    run = 1'b0;
    check("reaccept_T0", {29'd0, state}, 32'd1);
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("b2b_drain", {31'd0, busy}, 32'd0);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

`ifdef DATAPATH_CTRL_PERF_EN
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0040, 16'h0004, 1'b0, 1'b1);
    issue(8'b00_010_110, "perf_mv");
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0002, 16'h0200, 1'b0, 1'b0);
    push(3'd3, 16'h0010, 16'h0100, 1'b0, 1'b0);
    push(3'd4, 16'h0100, 16'h0002, 1'b0, 1'b1);
    issue(8'b10_001_100, "perf_add");
    push(3'd1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    push(3'd2, 16'h0020, 16'h0200, 1'b0, 1'b0);
    push(3'd3, 16'h0020, 16'h0100, 1'b1, 1'b0);
    push(3'd4, 16'h0100, 16'h0020, 1'b0, 1'b1);
    issue(8'b11_101_101, "perf_xor");
    check("instr_count", {16'd0, instr_count}, 32'd3);
    check("last_op", {30'd0, last_op}, 32'd3);
    reset = 1'b1;
    #1;
    check("instr_count_reset", {16'd0, instr_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
